// File: rtl/anneal_accept_ctrl.sv
// anneal_accept_ctrl: initiator side of the annealing acceptance handshake.
// Downhill/equal moves accept at once; uphill moves request a probability
// from the probability computer and compare it against an LFSR draw.
// Optional build macro ACCEPT_STATS_EN adds saturating decision counters.
module anneal_accept_ctrl #(
   parameter int          PROB_W    = 24,
   parameter int          TIMEOUT   = 1023,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] new_cost,
   input  logic [31:0] old_cost,
   input  logic [31:0] tinv,
   output logic [31:0] pc_new,
   output logic [31:0] pc_old,
   output logic [31:0] pc_tinv,
   output logic        pc_valid,
   input  logic [31:0] pc_prob,
   input  logic        pc_prob_valid,
   output logic        acc_valid,
   output logic        acc,
   output logic        acc_timeout,
   input  logic        acc_ready
`ifdef ACCEPT_STATS_EN
   ,
   output logic [31:0] stat_accepts,
   output logic [31:0] stat_rejects,
   output logic [15:0] stat_timeouts
`endif
);

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   // Low PROB_W bits; masking the full words keeps every input bit in use.
   localparam logic [31:0] PROB_MASK = 32'((64'd1 << PROB_W) - 64'd1);
   localparam int          CNT_W     = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic [31:0] new_c;
      logic [31:0] old_c;
      logic [31:0] tinv;
   } move_t;

   state_t             state_q, state_d;
   move_t              move_q, move_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               acc_q, acc_d;
   logic               tmo_q, tmo_d;
   logic               rdy_q;
   logic [31:0]        rnd_m, prob_m;

   assign rnd_m  = lfsr_q & PROB_MASK;
   assign prob_m = pc_prob & PROB_MASK;

   // Galois LFSR, shifts right, free-running out of reset
   always_comb begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
   end

   // Next-state and decision logic
   always_comb begin
      state_d = state_q;
      move_d  = move_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && rdy_q) begin
               move_d = '{new_c: new_cost, old_c: old_cost, tinv: tinv};
               acc_d  = 1'b0;
               tmo_d  = 1'b0;
               if (new_cost <= old_cost) begin
                  acc_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A result arriving on the timeout cycle still wins
            if (pc_prob_valid) begin
               acc_d   = (rnd_m < prob_m);
               tmo_d   = 1'b0;
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               acc_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (acc_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         move_q  <= '0;
         lfsr_q  <= LFSR_SEED;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         tmo_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         move_q  <= move_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         tmo_q   <= tmo_d;
         rdy_q   <= 1'b1;
      end
   end

   // rdy_q keeps req_ready low in the cycle right after a reset edge
   assign req_ready   = rdy_q && (state_q == S_IDLE);
   assign pc_valid    = (state_q == S_REQ);
   assign acc_valid   = (state_q == S_DONE);
   assign acc         = acc_q;
   assign acc_timeout = tmo_q;
   assign pc_new      = move_q.new_c;
   assign pc_old      = move_q.old_c;
   assign pc_tinv     = move_q.tinv;

`ifdef ACCEPT_STATS_EN
   logic [31:0] st_acc_q, st_rej_q;
   logic [15:0] st_tmo_q;

   // Saturating counters bumped on the decision handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_acc_q <= '0;
         st_rej_q <= '0;
         st_tmo_q <= '0;
      end else if (state_q == S_DONE && acc_ready) begin
         if (acc_q) begin
            if (st_acc_q != '1) st_acc_q <= st_acc_q + 1'b1;
         end else begin
            if (st_rej_q != '1) st_rej_q <= st_rej_q + 1'b1;
         end
         if (tmo_q && st_tmo_q != '1) st_tmo_q <= st_tmo_q + 1'b1;
      end
   end

   assign stat_accepts  = st_acc_q;
   assign stat_rejects  = st_rej_q;
   assign stat_timeouts = st_tmo_q;
`endif

endmodule

// File: tb/tb_anneal_accept_ctrl.sv
// Directed bench for anneal_accept_ctrl. Inputs change and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_anneal_accept_ctrl;

   localparam int          TMO  = 1023;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk, rst;
   logic        req_valid, req_ready;
   logic [31:0] new_cost, old_cost, tinv;
   logic [31:0] pc_new, pc_old, pc_tinv;
   logic        pc_valid;
   logic [31:0] pc_prob;
   logic        pc_prob_valid;
   logic        acc_valid, acc, acc_timeout, acc_ready;
`ifdef ACCEPT_STATS_EN
   logic [31:0] stat_accepts, stat_rejects;
   logic [15:0] stat_timeouts;
   int          e_acc = 0, e_rej = 0, e_tmo = 0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          pcv_cnt = 0;
   logic [31:0] m_lfsr;

   anneal_accept_ctrl #(.PROB_W(24), .TIMEOUT(TMO), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .new_cost(new_cost), .old_cost(old_cost), .tinv(tinv),
      .pc_new(pc_new), .pc_old(pc_old), .pc_tinv(pc_tinv), .pc_valid(pc_valid),
      .pc_prob(pc_prob), .pc_prob_valid(pc_prob_valid),
      .acc_valid(acc_valid), .acc(acc), .acc_timeout(acc_timeout),
      .acc_ready(acc_ready)
`ifdef ACCEPT_STATS_EN
      ,
      .stat_accepts(stat_accepts), .stat_rejects(stat_rejects),
      .stat_timeouts(stat_timeouts)
`endif
   );

   always #5 clk = ~clk;

   // Reference random source: 32-bit Galois LFSR, taps 8020_0003, seed on reset
   always @(posedge clk) begin
      if (!rst) m_lfsr <= SEED;
      else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
   end

   // Count request strobes to the probability computer
   always @(posedge clk) if (pc_valid === 1'b1) pcv_cnt <= pcv_cnt + 1;

   // Call on a falling edge with the DUT idle; returns one cycle after the accepting edge
   task automatic send(input logic [31:0] n, input logic [31:0] o, input logic [31:0] t);
      req_valid = 1'b1; new_cost = n; old_cost = o; tinv = t;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic handshake();
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
      checks++; if ({pc_valid, acc_valid, acc, acc_timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {pc_valid, acc_valid, acc, acc_timeout}); end
      checks++; if ({pc_new, pc_old, pc_tinv} !== 96'h0) begin errors++; $display("FAIL reset_pc_regs got %h want 0", {pc_new, pc_old, pc_tinv}); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", req_ready); end
   endtask

   task automatic test_downhill(input logic [31:0] n, input logic [31:0] o);
      int p0;
      p0 = pcv_cnt;
      send(n, o, 32'h3F00_0000);
      checks++; if ({acc_valid, acc, acc_timeout} !== 3'b110) begin errors++; $display("FAIL downhill_%0d_%0d got v/a/t %b want 110", n, o, {acc_valid, acc, acc_timeout}); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL downhill_busy got %0b want 0", req_ready); end
      handshake();
      checks++; if ({acc_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL downhill_release got v/rdy %b want 01", {acc_valid, req_ready}); end
      checks++; if (pcv_cnt !== p0) begin errors++; $display("FAIL downhill_no_pc_valid got %0d strobes want 0", pcv_cnt - p0); end
`ifdef ACCEPT_STATS_EN
      e_acc++;
`endif
   endtask

   task automatic test_uphill_zero();
      int p0;
      p0 = pcv_cnt;
      send(32'd200, 32'd100, 32'h3F80_0000);
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL up0_pc_valid got %0b want 1", pc_valid); end
      checks++; if ({pc_new, pc_old, pc_tinv} !== {32'd200, 32'd100, 32'h3F80_0000}) begin errors++; $display("FAIL up0_pc_regs got %h want c8/64/3f800000", {pc_new, pc_old, pc_tinv}); end
      @(negedge clk);
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL up0_pc_valid_pulse got %0b want 0", pc_valid); end
      repeat (5) @(negedge clk);
      checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL up0_early_valid got %0b want 0", acc_valid); end
      pc_prob = 32'h0; pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      checks++; if ({acc_valid, acc, acc_timeout} !== 3'b100) begin errors++; $display("FAIL up0_decision got v/a/t %b want 100", {acc_valid, acc, acc_timeout}); end
      checks++; if (pcv_cnt !== p0 + 1) begin errors++; $display("FAIL up0_strobe_count got %0d want 1", pcv_cnt - p0); end
      handshake();
`ifdef ACCEPT_STATS_EN
      e_rej++;
`endif
   endtask

   task automatic test_uphill_full_hold();
      logic [23:0] r;
      logic        exp_a;
      send(32'd300, 32'd100, 32'h4000_0000);
      repeat (2) @(negedge clk);
      r = m_lfsr[23:0];
      exp_a = (r != 24'hFF_FFFF);
      pc_prob = 32'h00FF_FFFF; pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      // A downhill request offered while busy must be ignored
      req_valid = 1'b1; new_cost = 32'd1; old_cost = 32'd2;
      for (int i = 0; i < 5; i++) begin
         checks++; if ({acc_valid, acc, req_ready} !== {1'b1, exp_a, 1'b0}) begin errors++; $display("FAIL hold_%0d got v/a/rdy %b want %b", i, {acc_valid, acc, req_ready}, {1'b1, exp_a, 1'b0}); end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++; if (pc_new !== 32'd300) begin errors++; $display("FAIL hold_pc_new got %0d want 300", pc_new); end
      handshake();
`ifdef ACCEPT_STATS_EN
      if (exp_a) e_acc++; else e_rej++;
`endif
   endtask

   // Probability equal to the draw rejects; one above it accepts
   task automatic test_prob_boundary(input logic plus_one);
      logic [23:0] r, pv;
      logic        exp_a;
      send(32'd1000, 32'd10, 32'h3E80_0000);
      repeat (3) @(negedge clk);
      r = m_lfsr[23:0];
      pv = plus_one ? r + 24'd1 : r;
      exp_a = plus_one && (r != 24'hFF_FFFF);
      pc_prob = {8'hAB, pv}; pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      checks++; if ({acc_valid, acc} !== {1'b1, exp_a}) begin errors++; $display("FAIL boundary_plus%0d got v/a %b want %b (rnd %h)", plus_one, {acc_valid, acc}, {1'b1, exp_a}, r); end
      handshake();
`ifdef ACCEPT_STATS_EN
      if (exp_a) e_acc++; else e_rej++;
`endif
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      send(32'd500, 32'd100, 32'h3F80_0000);
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL tmo_pc_valid got %0b want 1", pc_valid); end
      for (int k = 1; k <= TMO + 1; k++) begin
         @(negedge clk);
         if (acc_valid !== 1'b0) early++;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early_valid got %0d cycles want 0", early); end
      @(negedge clk);
      checks++; if ({acc_valid, acc, acc_timeout} !== 3'b101) begin errors++; $display("FAIL tmo_decision got v/a/t %b want 101", {acc_valid, acc, acc_timeout}); end
      // Late result while the forced decision is pending
      pc_prob = 32'h00FF_FFFF; pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      checks++; if ({acc_valid, acc, acc_timeout} !== 3'b101) begin errors++; $display("FAIL tmo_late_done got v/a/t %b want 101", {acc_valid, acc, acc_timeout}); end
      handshake();
      pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      checks++; if ({req_ready, acc_valid, pc_valid} !== 3'b100) begin errors++; $display("FAIL tmo_late_idle got rdy/v/pcv %b want 100", {req_ready, acc_valid, pc_valid}); end
`ifdef ACCEPT_STATS_EN
      e_rej++; e_tmo++;
`endif
   endtask

   task automatic test_stats();
`ifdef ACCEPT_STATS_EN
      checks++; if ({stat_accepts, stat_rejects, stat_timeouts} !== {e_acc[31:0], e_rej[31:0], e_tmo[15:0]}) begin errors++; $display("FAIL stats got %0d/%0d/%0d want %0d/%0d/%0d", stat_accepts, stat_rejects, stat_timeouts, e_acc, e_rej, e_tmo); end
`endif
   endtask

   task automatic test_reset_mid_wait();
      send(32'd900, 32'd100, 32'h3F80_0000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({acc_valid, req_ready, pc_valid} !== 3'b000) begin errors++; $display("FAIL midrst_during got v/rdy/pcv %b want 000", {acc_valid, req_ready, pc_valid}); end
      rst = 1'b1;
      pc_prob = 32'h00FF_FFFF; pc_prob_valid = 1'b1;
      @(negedge clk);
      pc_prob_valid = 1'b0;
      checks++; if ({acc_valid, req_ready, pc_valid} !== 3'b010) begin errors++; $display("FAIL midrst_after got v/rdy/pcv %b want 010", {acc_valid, req_ready, pc_valid}); end
`ifdef ACCEPT_STATS_EN
      e_acc = 0; e_rej = 0; e_tmo = 0;
      test_stats();
`endif
      test_downhill(32'd7, 32'd9);
   endtask

   initial begin
      clk = 1'b0; rst = 1'b0;
      req_valid = 1'b0; new_cost = '0; old_cost = '0; tinv = '0;
      pc_prob = '0; pc_prob_valid = 1'b0; acc_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_downhill(32'd100, 32'd150);
      test_downhill(32'd150, 32'd150);
      test_uphill_zero();
      test_uphill_full_hold();
      test_prob_boundary(1'b0);
      test_prob_boundary(1'b1);
      test_timeout();
      test_downhill(32'd5, 32'd6);
      checks++; if (acc_timeout !== 1'b0) begin errors++; $display("FAIL back_to_back_tmo_clear got %0b want 0", acc_timeout); end
      test_stats();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
